// File: rtl/pwm_bank_pkg.sv
// Shared constants for the PWM bank: register map, ctrl bit positions and
// the counter mode enumeration.
package pwm_bank_pkg;

    localparam logic [7:0] AddrOutEn    = 8'h00;
    localparam logic [7:0] AddrPwmEn    = 8'h04;
    localparam logic [7:0] AddrPeriod   = 8'h08;
    localparam logic [7:0] AddrPrescale = 8'h09;
    localparam logic [7:0] AddrCtrl     = 8'h0A;
    localparam logic [7:0] AddrDuty     = 8'h10;

    localparam int unsigned CtrlCenter = 0;
    localparam int unsigned CtrlRun    = 1;

    typedef enum logic {
        ModeEdge   = 1'b0,
        ModeCenter = 1'b1
    } mode_e;

endpackage

// File: rtl/pwm_bank_if.sv
// Register write port and channel outputs of the PWM bank.
interface pwm_bank_if #(
    parameter int unsigned NUM_CH = 16
) ();

    logic              wr_en;
    logic [7:0]        wr_addr;
    logic [7:0]        wr_data;
    logic [NUM_CH-1:0] out;
    logic              cycle_start;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  out, cycle_start
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output out, cycle_start
    );

endinterface

// File: rtl/pwm_timebase.sv
// Prescaler plus edge-aligned (up) or center-aligned (up/down) period counter.
// boundary flags the tick on which the counter returns to 0.
module pwm_timebase
    import pwm_bank_pkg::*;
#(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  mode_e            mode,
    input  logic [CNT_W-1:0] period,
    input  logic [7:0]       prescale,
    output logic [CNT_W-1:0] count,
    output logic             tick,
    output logic             boundary
);

    logic [7:0]       psc_q, psc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             down_q, down_d;

    always_comb begin
        // >= so a prescale lowered below the running count still ticks
        tick     = run && (psc_q >= prescale);
        psc_d    = (!run || tick) ? 8'd0 : psc_q + 8'd1;
        cnt_d    = cnt_q;
        down_d   = down_q;
        boundary = 1'b0;
        if (!run) begin
            cnt_d  = '0;
            down_d = 1'b0;
        end else if (tick) begin
            if (cnt_q > period || period == '0) begin
                boundary = 1'b1;
            end else if (mode == ModeEdge) begin
                down_d = 1'b0;
                if (cnt_q == period) boundary = 1'b1;
                else                 cnt_d = cnt_q + CNT_W'(1);
            end else if (!down_q) begin
                if (cnt_q != period) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (cnt_q == CNT_W'(1)) begin
                    boundary = 1'b1;
                end else begin
                    cnt_d  = cnt_q - CNT_W'(1);
                    down_d = 1'b1;
                end
            end else if (cnt_q <= CNT_W'(1)) begin
                boundary = 1'b1;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            if (boundary) begin
                cnt_d  = '0;
                down_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psc_q  <= 8'd0;
            cnt_q  <= '0;
            down_q <= 1'b0;
        end else begin
            psc_q  <= psc_d;
            cnt_q  <= cnt_d;
            down_q <= down_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/pwm_bank.sv
// Bank of NUM_CH PWM channels sharing one timebase; duty/period writes are
// shadowed and take effect at the next period boundary.
module pwm_bank
    import pwm_bank_pkg::*;
#(
    parameter int unsigned NUM_CH = 16,
    parameter int unsigned CNT_W  = 8
) (
    input logic        clk,
    input logic        rst,
    pwm_bank_if.slave  bus
);

    logic [NUM_CH-1:0] out_en_q, out_en_d, pwm_en_q, pwm_en_d, out_q, out_d;
    logic [CNT_W-1:0]  period_sh_q, period_sh_d, period_q, period_d;
    logic [CNT_W-1:0]  duty_sh_q [NUM_CH];
    logic [CNT_W-1:0]  duty_sh_d [NUM_CH];
    logic [CNT_W-1:0]  duty_q    [NUM_CH];
    logic [CNT_W-1:0]  duty_d    [NUM_CH];
    logic [7:0]        prescale_q, prescale_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              cycle_start_q;
    logic              run, tick, boundary;
    mode_e             mode;
    logic [CNT_W-1:0]  count;

    assign run  = ctrl_q[CtrlRun];
    assign mode = mode_e'(ctrl_q[CtrlCenter]);

    pwm_timebase #(
        .CNT_W (CNT_W)
    ) u_timebase (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .mode     (mode),
        .period   (period_q),
        .prescale (prescale_q),
        .count    (count),
        .tick     (tick),
        .boundary (boundary)
    );

    always_comb begin
        out_en_d    = out_en_q;
        pwm_en_d    = pwm_en_q;
        period_sh_d = period_sh_q;
        duty_sh_d   = duty_sh_q;
        prescale_d  = prescale_q;
        ctrl_d      = ctrl_q;
        if (bus.wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.wr_addr == AddrOutEn + 8'(i / 8)) out_en_d[i] = bus.wr_data[i[2:0]];
                if (bus.wr_addr == AddrPwmEn + 8'(i / 8)) pwm_en_d[i] = bus.wr_data[i[2:0]];
                if (bus.wr_addr == AddrDuty + 8'(i)) duty_sh_d[i] = bus.wr_data[CNT_W-1:0];
            end
            if (bus.wr_addr == AddrPeriod)   period_sh_d = bus.wr_data[CNT_W-1:0];
            if (bus.wr_addr == AddrPrescale) prescale_d  = bus.wr_data;
            if (bus.wr_addr == AddrCtrl)     ctrl_d      = bus.wr_data[1:0];
        end
    end

    // A shadow write landing on the boundary edge itself misses this copy.
    always_comb begin
        period_d = period_q;
        duty_d   = duty_q;
        if (!run || (tick && boundary)) begin
            period_d = period_sh_q;
            duty_d   = duty_sh_q;
        end
    end

    always_comb begin
        out_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            out_d[i] = out_en_q[i] & (~pwm_en_q[i] | (run & (count < duty_q[i])));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_en_q      <= '0;
            pwm_en_q      <= '0;
            period_sh_q   <= '1;
            period_q      <= '1;
            prescale_q    <= 8'd0;
            ctrl_q        <= 2'b10;
            out_q         <= '0;
            cycle_start_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                duty_sh_q[i] <= '0;
                duty_q[i]    <= '0;
            end
        end else begin
            out_en_q      <= out_en_d;
            pwm_en_q      <= pwm_en_d;
            period_sh_q   <= period_sh_d;
            period_q      <= period_d;
            prescale_q    <= prescale_d;
            ctrl_q        <= ctrl_d;
            out_q         <= out_d;
            cycle_start_q <= tick & boundary;
            duty_sh_q     <= duty_sh_d;
            duty_q        <= duty_d;
        end
    end

    assign bus.out         = out_q;
    assign bus.cycle_start = cycle_start_q;

endmodule

// File: tb/tb_pwm_bank.sv
// Scoreboard bench for pwm_bank: expected pulse widths and intervals are queued
// when a scenario is configured and popped as the outputs are measured.
module tb_pwm_bank;

    localparam int unsigned NumCh = 16;
    localparam int Budget = 2000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_bank_if #(.NUM_CH(NumCh)) bus ();

    pwm_bank #(
        .NUM_CH (NumCh),
        .CNT_W  (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int unsigned exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int unsigned v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input int unsigned got);
        if (exp_q.size() == 0) check({tag, "_noexp"}, got, 32'hFFFF_FFFF);
        else                   check(tag, got, exp_q.pop_front());
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.wr_en   = 1'b1;
        bus.wr_addr = a;
        bus.wr_data = d;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic wait_rise(input string tag, input int ch);
        logic prev;
        int   n;
        bit   to;
        prev = bus.out[ch];
        n    = 0;
        to   = 1'b0;
        forever begin
            @(negedge clk);
            n++;
            if (!prev && bus.out[ch]) break;
            prev = bus.out[ch];
            if (n >= Budget) begin
                to = 1'b1;
                break;
            end
        end
        if (to) check({tag, "_timeout"}, 32'(to), 0);
    endtask

    task automatic run_len(input int ch, input logic val, output int n);
        n = 0;
        while (bus.out[ch] == val && n < Budget) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic measure_pwm(input string tag, input int ch);
        int h, l;
        wait_rise(tag, ch);
        run_len(ch, 1'b1, h);
        sb_check({tag, "_high"}, h);
        run_len(ch, 1'b0, l);
        sb_check({tag, "_low"}, l);
    endtask

    task automatic cs_interval(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cycle_start && n < Budget);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cycle_start && n < Budget);
        sb_check(tag, n);
    endtask

    task automatic count_val(input int ch, input logic val, input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (bus.out[ch] == val) n++;
        end
    endtask

    initial begin
        int n, m;
        bus.wr_en   = 1'b0;
        bus.wr_addr = 8'h00;
        bus.wr_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", 32'(bus.out), 0);
        check("rst_cs", 32'(bus.cycle_start), 0);
        rst = 1'b0;

        // Edge mode, period 255, duty 64 on ch0
        wr(8'h10, 8'd64);
        wr(8'h00, 8'h01);
        wr(8'h04, 8'h01);
        sb_push(64); sb_push(192); sb_push(64); sb_push(192); sb_push(256);
        measure_pwm("edge64_a", 0);
        measure_pwm("edge64_b", 0);
        cs_interval("edge64_cs");

        // Prescale 2, period 3, duty 2: counter steps every 3 clks
        wr(8'h0A, 8'h00);
        wr(8'h08, 8'd3);
        wr(8'h09, 8'd2);
        wr(8'h10, 8'd2);
        wr(8'h0A, 8'h02);
        sb_push(6); sb_push(6); sb_push(12);
        measure_pwm("psc", 0);
        cs_interval("psc_cs");

        // Global run off: no cycle_start, PWM channel low
        wr(8'h0A, 8'h00);
        @(negedge clk);
        n = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (bus.cycle_start) n++;
        end
        count_val(0, 1'b1, 50, m);
        sb_push(0); sb_push(0);
        sb_check("stop_cs", n);
        sb_check("stop_out", m);

        // Center mode, period 4, duty 2 on ch3
        wr(8'h09, 8'd0);
        wr(8'h0A, 8'h01);
        wr(8'h08, 8'd4);
        wr(8'h13, 8'd2);
        wr(8'h00, 8'h08);
        wr(8'h04, 8'h08);
        wr(8'h0A, 8'h03);
        sb_push(3); sb_push(5); sb_push(8);
        wait_rise("ctr_skip", 3);
        measure_pwm("ctr", 3);
        cs_interval("ctr_cs");

        // Duty 10 -> 200 written mid-period on ch1
        wr(8'h0A, 8'h00);
        wr(8'h08, 8'd255);
        wr(8'h11, 8'd10);
        wr(8'h00, 8'h02);
        wr(8'h04, 8'h02);
        wr(8'h0A, 8'h02);
        sb_push(10); sb_push(200); sb_push(56);
        wait_rise("dchg", 1);
        run_len(1, 1'b1, n);
        sb_check("dchg_old", n);
        wr(8'h11, 8'd200);
        run_len(1, 1'b0, n);
        run_len(1, 1'b1, n);
        sb_check("dchg_new", n);
        run_len(1, 1'b0, n);
        sb_check("dchg_low", n);

        // Extremes on ch2: duty 0 then duty above period 254
        wr(8'h0A, 8'h00);
        wr(8'h08, 8'd254);
        wr(8'h12, 8'd0);
        wr(8'h00, 8'h04);
        wr(8'h04, 8'h04);
        wr(8'h0A, 8'h02);
        sb_push(0); sb_push(0); sb_push(0);
        count_val(2, 1'b1, 600, n);
        sb_check("duty0_ones", n);
        wr(8'h12, 8'd255);
        n = 0;
        m = 0;
        do begin
            @(negedge clk);
            m++;
            if (bus.out[2]) n++;
        end while (!bus.cycle_start && m < Budget);
        sb_check("dutymax_pre_ones", n);
        @(negedge clk);
        count_val(2, 1'b0, 600, n);
        sb_check("dutymax_zeros", n);

        // Forced-high channel 5, then disabled
        wr(8'h00, 8'h20);
        wr(8'h04, 8'h00);
        repeat (2) @(negedge clk);
        sb_push(0); sb_push(0); sb_push(0);
        count_val(5, 1'b0, 100, n);
        sb_check("force5_zeros", n);
        wr(8'h00, 8'h00);
        @(negedge clk);
        sb_check("off5", 32'(bus.out[5]));

        // Bytes/channels beyond NUM_CH are ignored
        wr(8'h02, 8'hFF);
        wr(8'h06, 8'hFF);
        wr(8'h0B, 8'hFF);
        repeat (2) @(negedge clk);
        sb_check("ignored_out", 32'(bus.out));

        // Mid-period reset with a pending duty write
        wr(8'h0A, 8'h00);
        wr(8'h08, 8'd255);
        wr(8'h10, 8'd64);
        wr(8'h00, 8'h01);
        wr(8'h04, 8'h01);
        wr(8'h0A, 8'h02);
        wait_rise("rst_mid", 0);
        wr(8'h10, 8'd128);
        sb_push(0); sb_push(0); sb_push(256); sb_push(0);
        #2 rst = 1'b1;
        #1;
        sb_check("rst_async_out", 32'(bus.out));
        sb_check("rst_async_cs", 32'(bus.cycle_start));
        @(negedge clk);
        rst = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cycle_start && n < Budget);
        sb_check("rst_first_period", n);
        wr(8'h00, 8'h01);
        wr(8'h04, 8'h01);
        count_val(0, 1'b1, 600, n);
        sb_check("rst_pending_dropped", n);

        check("sb_drained", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 Parameter NUM_CH, default 16: channel count, legal 1..32.
REQ-002 Parameter CNT_W, default 8: counter/duty/period width, legal 1..8.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_en  input  1  register write strobe, one write per high cycle.
REQ-006 wr_addr  input  8  register address.
REQ-007 wr_data  input  8  write data; period/duty use bits [CNT_W-1:0].
REQ-008 out  output  NUM_CH  registered channel outputs.
REQ-009 cycle_start  output  1  one-clk pulse at each PWM period boundary.

Function
REQ-010 Address map SHALL be: 0x00-0x03 out_en bytes; 0x04-0x07 pwm_en bytes; 0x08 period; 0x09 prescale; 0x0A ctrl (bit0 center mode, bit1 global run); 0x10+i duty[i]; other addresses and bits beyond NUM_CH SHALL be ignored.
REQ-011 A write SHALL update its register on the wr_en clock edge; out_en, pwm_en, prescale and ctrl take effect immediately.
REQ-012 Duty and period writes SHALL go to shadow registers, copied to active registers only at a period boundary or while global run = 0.
REQ-013 Prescaler SHALL generate a tick every (prescale+1) clk cycles; prescale = 0 -> tick every cycle.
REQ-014 Edge mode: counter SHALL step 0..period on ticks, then wrap to 0; period = (period+1)*(prescale+1) clks.
REQ-015 Center mode: counter SHALL step up 0..period, then down period-1..1, then 0; period = 2*period*(prescale+1) clks; period = 0 -> counter stays 0, every tick a boundary.
REQ-016 Boundary SHALL be the tick on which the counter becomes 0; cycle_start SHALL pulse in the clk cycle the counter equals 0 after that tick.
REQ-017 Channel i: out_en[i] = 0 -> 0; else pwm_en[i] = 0 -> 1; else (counter < active duty[i]).
REQ-018 duty = 0 SHALL give constant 0; duty > active period SHALL give constant 1; no glitch pulses at either extreme.
REQ-019 out SHALL be registered: one clk latency from counter/enable state to out.
REQ-020 Global run = 0: prescaler and counter held at 0, PWM-mode channels output 0, no cycle_start; run 0->1 SHALL start a period at counter 0.
REQ-021 Mode change mid-period SHALL take effect on the next tick from the current counter value; counter > new period SHALL load 0 on the next tick (treated as boundary).
REQ-022 Duty write on the boundary cycle itself SHALL be used from the following period.

Reset
REQ-023 rst high SHALL asynchronously clear counter, prescaler, enables, duties, prescale, out, cycle_start to 0.
REQ-024 Reset SHALL set period (active and shadow) to all ones and ctrl to 0x02 (edge mode, running).
REQ-025 Reset asserted mid-period SHALL abandon pending shadow writes; first period after release starts at counter 0.

Structure
REQ-026 Shared package pwm_bank_pkg SHALL hold address constants, ctrl bit indices and the edge/center mode enum.
REQ-027 Prescaler and up/up-down counter SHALL be one sub-module, pwm_timebase, emitting count, tick and boundary.

Verification
REQ-028 CNT_W=8, period 255, prescale 0, duty[0]=64, ch0 out/pwm enabled -> out[0] high 64 clks, low 192, repeating every 256.
REQ-029 Center mode, period 4, prescale 0, duty[3]=2 -> out[3] high 3 clks (wrapping boundary), low 5, period 8; cycle_start every 8 clks.
REQ-030 Duty[1] 10->200 written mid-period (period 255) -> current period keeps 10-clk high; next period 200-clk high.
REQ-031 duty[2]=0 then 255 with period 254 -> out[2] constant 0, then constant 1 from next boundary, no pulses.
REQ-032 out_en[5]=1, pwm_en[5]=0 -> out[5]=1 steady; out_en[5]=0 -> 0 one clk after write.
REQ-033 rst asserted mid-period with pending duty write -> out all 0 immediately; after release counter restarts at 0, pending duty discarded.
